// File: rtl/rv_pkg.sv
// Shared RV32I decode types: alu opcodes, instruction field constants and the
// registered decode payload handed from id_stage to alu.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned SHADOW_DEF = 4;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_AND    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SRL    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_ONE    = 4'd6,
        ALU_ZERO   = 4'd7,
        ALU_BRANCH = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_LUI    = 4'd10,
        ALU_SUB    = 4'd11,
        ALU_AUIPC  = 4'd12
    } alu_op_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_fmt_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } shadow_state_t;

    typedef struct packed {
        alu_op_t         op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            we;
        logic            redirect;
        logic [XLEN-1:0] link;
        logic            illegal;
        logic            vld;
    } id_out_t;

    // Branch outcome from the shared comparator results.
    function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                          input logic lt, input logic ltu);
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Immediate extraction for the RV32I formats. U yields the raw 20-bit upper
// field zero-extended; alu positions it for LUI/AUIPC.
module id_imm_gen
    import rv_pkg::*;
(
    input  logic [31:7]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm_c
);

    always_comb begin
        imm_c = '0;
        case (fmt)
            IMM_I: imm_c = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U: imm_c = {12'b0, instr[31:12]};
            IMM_J: imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes one instruction per cycle into alu operands,
// resolves compares locally and squashes the fetch shadow behind redirects.
module id_stage
    import rv_pkg::*;
#(
    parameter int unsigned SHADOW = SHADOW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            instr_vld_i,
    input  logic            stall_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output alu_op_t         alu_op_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] link_o,
    output logic            illegal_o,
    output logic            vld_o
);

    localparam int unsigned CNT_W = $clog2(SHADOW + 1);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            alt;
    logic            rd_nz;
    imm_fmt_t        fmt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] cmp_b;
    logic            eq;
    logic            lt;
    logic            ltu;
    id_out_t         dec;
    id_out_t         out_d;
    id_out_t         out_q;
    shadow_state_t   state_d;
    shadow_state_t   state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign opcode     = instr_i[6:0];
    assign f3         = instr_i[14:12];
    assign alt        = instr_i[30];
    assign rd_nz      = |instr_i[11:7];
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];
    assign shamt      = XLEN'(instr_i[24:20]);

    // Immediate format follows the opcode class.
    always_comb begin
        fmt = IMM_I;
        case (opcode)
            OPC_STORE:            fmt = IMM_S;
            OPC_BRANCH:           fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:   fmt = IMM_U;
            OPC_JAL:              fmt = IMM_J;
            default:              fmt = IMM_I;
        endcase
    end

    id_imm_gen u_imm_gen (
        .instr (instr_i[31:7]),
        .fmt   (fmt),
        .imm_c (imm)
    );

    // One comparator serves SLT(I)(U) and branches.
    assign cmp_b = (opcode == OPC_OP_IMM) ? imm : rs2_data_i;
    assign eq    = (rs1_data_i == cmp_b);
    assign lt    = ($signed(rs1_data_i) < $signed(cmp_b));
    assign ltu   = (rs1_data_i < cmp_b);

    always_comb begin
        dec     = '0;
        dec.op  = ALU_ADD;
        dec.rd  = instr_i[11:7];
        dec.vld = 1'b1;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec.a  = rs1_data_i;
                dec.b  = (opcode == OPC_OP) ? rs2_data_i : imm;
                dec.we = rd_nz;
                if (opcode == OPC_OP_IMM && (f3 == F3_SLL || f3 == F3_SR)) begin
                    dec.b = shamt;
                end
                case (f3)
                    F3_ADD:  dec.op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  dec.op = ALU_SLL;
                    F3_SLT, F3_SLTU: begin
                        dec.op = ((f3 == F3_SLT) ? lt : ltu) ? ALU_ONE : ALU_ZERO;
                        dec.a  = '0;
                        dec.b  = '0;
                    end
                    F3_XOR:  dec.op = ALU_XOR;
                    F3_SR:   dec.op = alt ? ALU_SRA : ALU_SRL;
                    F3_OR:   dec.op = ALU_OR;
                    default: dec.op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec.op = ALU_LUI;
                dec.b  = imm;
                dec.we = rd_nz;
            end
            OPC_AUIPC: begin
                dec.op = ALU_AUIPC;
                dec.a  = pc_i;
                dec.b  = imm;
                dec.we = rd_nz;
            end
            OPC_JAL: begin
                dec.a        = pc_i;
                dec.b        = imm;
                dec.we       = rd_nz;
                dec.redirect = 1'b1;
                dec.link     = pc_i + XLEN'(4);
            end
            OPC_JALR: begin
                if (f3 == 3'd0) begin
                    dec.a        = rs1_data_i;
                    dec.b        = imm;
                    dec.we       = rd_nz;
                    dec.redirect = 1'b1;
                    dec.link     = pc_i + XLEN'(4);
                end else begin
                    dec.op      = ALU_ZERO;
                    dec.illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    dec.op      = ALU_ZERO;
                    dec.illegal = 1'b1;
                end else begin
                    // Not-taken still redirects: alu BRANCH computes the fall-through PC.
                    dec.a        = pc_i;
                    dec.redirect = 1'b1;
                    if (branch_taken(f3, eq, lt, ltu)) begin
                        dec.b = imm;
                    end else begin
                        dec.op = ALU_BRANCH;
                    end
                end
            end
            default: begin
                dec.op      = ALU_ZERO;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Shadow FSM and output selection; bubbles are the all-zero payload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = '0;
        out_d.op = ALU_ADD;
        case (state_q)
            ST_IDLE: begin
                if (instr_vld_i) begin
                    out_d = dec;
                    if (dec.redirect) begin
                        state_d = ST_SQUASH;
                        cnt_d   = CNT_W'(SHADOW);
                    end
                end
            end
            ST_SQUASH: begin
                if (instr_vld_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else if (!stall_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign alu_op_o   = out_q.op;
    assign alu_a_o    = out_q.a;
    assign alu_b_o    = out_q.b;
    assign rd_addr_o  = out_q.rd;
    assign rd_we_o    = out_q.we;
    assign redirect_o = out_q.redirect;
    assign link_o     = out_q.link;
    assign illegal_o  = out_q.illegal;
    assign vld_o      = out_q.vld;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, shadow/stall/reset
// sequences and randomized traffic against a behavioural decode model.
module tb_id_stage;

    localparam int SHADOW = 4;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        redirect;
        logic [31:0] link;
        logic        illegal;
        logic        vld;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] x1;
        logic [31:0] x2;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_vld;
    logic        stall;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    rv_pkg::alu_op_t alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        redirect;
    logic [31:0] link;
    logic        illegal;
    logic        vld;

    int   checks = 0;
    int   failures = 0;
    exp_t m_out;
    int   m_cnt;
    vec_t vt[16];

    always #5 clk = ~clk;

    id_stage #(.SHADOW(SHADOW)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_i     (instr),
        .pc_i        (pc),
        .instr_vld_i (instr_vld),
        .stall_i     (stall),
        .rs1_addr_o  (rs1_addr),
        .rs2_addr_o  (rs2_addr),
        .rs1_data_i  (rs1_data),
        .rs2_data_i  (rs2_data),
        .alu_op_o    (alu_op),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .rd_addr_o   (rd_addr),
        .rd_we_o     (rd_we),
        .redirect_o  (redirect),
        .link_o      (link),
        .illegal_o   (illegal),
        .vld_o       (vld)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
        input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {f7, r2, r1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, r1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
        input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
        input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
        input logic [4:0] rd, input logic we, input logic red, input logic [31:0] lnk,
        input logic ill);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.rd = rd; e.we = we; e.redirect = red;
        e.link = lnk; e.illegal = ill; e.vld = 1'b1;
        return e;
    endfunction

    // Architectural decode rules written from the instruction-set view.
    function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] p,
        input logic [31:0] x1, input logic [31:0] x2);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [31:0] imm_i, imm_b, imm_j, upper, opb;
        logic less, taken;
        opc   = ins[6:0];
        f3    = ins[14:12];
        imm_i = 32'($signed(ins[31:20]));
        imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        upper = 32'(ins[31:12]);
        e = '0;
        e.vld = 1'b1;
        e.rd  = ins[11:7];
        if (opc == 7'h33 || opc == 7'h13) begin
            opb = (opc == 7'h33) ? x2 : imm_i;
            if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) opb = 32'(ins[24:20]);
            e.we = (ins[11:7] != 5'd0);
            e.a  = x1;
            e.b  = opb;
            case (f3)
                3'd0: e.op = (opc == 7'h33 && ins[30]) ? 4'd11 : 4'd0;
                3'd1: e.op = 4'd2;
                3'd2, 3'd3: begin
                    less = (f3 == 3'd2) ? ($signed(x1) < $signed(opb)) : (x1 < opb);
                    e.op = less ? 4'd6 : 4'd7;
                    e.a  = 32'd0;
                    e.b  = 32'd0;
                end
                3'd4: e.op = 4'd5;
                3'd5: e.op = ins[30] ? 4'd9 : 4'd3;
                3'd6: e.op = 4'd4;
                default: e.op = 4'd1;
            endcase
        end else if (opc == 7'h37) begin
            e.op = 4'd10; e.b = upper; e.we = (ins[11:7] != 5'd0);
        end else if (opc == 7'h17) begin
            e.op = 4'd12; e.a = p; e.b = upper; e.we = (ins[11:7] != 5'd0);
        end else if (opc == 7'h6f || (opc == 7'h67 && f3 == 3'd0)) begin
            e.a = (opc == 7'h6f) ? p : x1;
            e.b = (opc == 7'h6f) ? imm_j : imm_i;
            e.redirect = 1'b1;
            e.link = p + 32'd4;
            e.we = (ins[11:7] != 5'd0);
        end else if (opc == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
            case (f3)
                3'd0: taken = (x1 == x2);
                3'd1: taken = (x1 != x2);
                3'd4: taken = ($signed(x1) < $signed(x2));
                3'd5: taken = ($signed(x1) >= $signed(x2));
                3'd6: taken = (x1 < x2);
                default: taken = (x1 >= x2);
            endcase
            e.redirect = 1'b1;
            e.a = p;
            e.op = taken ? 4'd0 : 4'd8;
            e.b = taken ? imm_b : 32'd0;
        end else begin
            e.op = 4'd7;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t dut_now();
        exp_t e;
        e.op = 4'(alu_op); e.a = alu_a; e.b = alu_b; e.rd = rd_addr; e.we = rd_we;
        e.redirect = redirect; e.link = link; e.illegal = illegal; e.vld = vld;
        return e;
    endfunction

    task automatic check(input string name, input exp_t want);
        exp_t got;
        got = dut_now();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got op=%0d a=%h b=%h rd=%0d we=%b red=%b link=%h ill=%b vld=%b | want op=%0d a=%h b=%h rd=%0d we=%b red=%b link=%h ill=%b vld=%b",
                name, got.op, got.a, got.b, got.rd, got.we, got.redirect, got.link, got.illegal, got.vld,
                want.op, want.a, want.b, want.rd, want.we, want.redirect, want.link, want.illegal, want.vld);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, advance the model alongside the DUT and compare.
    task automatic cycle(input string name, input logic v, input logic s, input logic r,
        input logic [31:0] ins, input logic [31:0] p, input logic [31:0] x1, input logic [31:0] x2);
        instr = ins; pc = p; instr_vld = v; stall = s; rst = r; rs1_data = x1; rs2_data = x2;
        #1;
        checks++;
        if ({rs1_addr, rs2_addr} !== {ins[19:15], ins[24:20]}) begin
            failures++;
            $display("FAIL %s rs_addr: got %0d/%0d want %0d/%0d", name, rs1_addr, rs2_addr,
                ins[19:15], ins[24:20]);
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_out = '0;
            m_cnt = 0;
        end else if (!s) begin
            if (m_cnt > 0) begin
                m_out = '0;
                if (v) m_cnt--;
            end else if (v) begin
                m_out = model_dec(ins, p, x1, x2);
                if (m_out.redirect) m_cnt = SHADOW;
            end else begin
                m_out = '0;
            end
        end
        check(name, m_out);
    endtask

    logic [31:0] add_i;
    logic [31:0] ri;
    logic [6:0]  opcs[10];

    initial begin
        m_out = '0; m_cnt = 0;
        rst = 1'b1; instr = 32'd0; pc = 32'd0; instr_vld = 1'b0; stall = 1'b0;
        rs1_data = 32'd0; rs2_data = 32'd0;
        add_i = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);

        vt[0]  = '{"add",    add_i, 32'h0, 32'd5, 32'd7, mk(4'd0, 32'd5, 32'd7, 5'd3, 1, 0, 0, 0)};
        vt[1]  = '{"sub",    enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33), 32'h0, 32'h80000000, 32'd1,
                   mk(4'd11, 32'h80000000, 32'd1, 5'd4, 1, 0, 0, 0)};
        vt[2]  = '{"srai",   enc_i(12'h404, 5'd1, 3'd5, 5'd5, 7'h13), 32'h0, 32'h80000000, 32'd0,
                   mk(4'd9, 32'h80000000, 32'd4, 5'd5, 1, 0, 0, 0)};
        vt[3]  = '{"sltu",   enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd6, 7'h33), 32'h0, 32'd1, 32'hFFFFFFFF,
                   mk(4'd6, 32'd0, 32'd0, 5'd6, 1, 0, 0, 0)};
        vt[4]  = '{"slt",    enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd6, 7'h33), 32'h0, 32'd1, 32'hFFFFFFFF,
                   mk(4'd7, 32'd0, 32'd0, 5'd6, 1, 0, 0, 0)};
        vt[5]  = '{"lui",    enc_u(20'h12345, 5'd7, 7'h37), 32'h0, 32'd0, 32'd0,
                   mk(4'd10, 32'd0, 32'h00012345, 5'd7, 1, 0, 0, 0)};
        vt[6]  = '{"auipc",  enc_u(20'h12345, 5'd8, 7'h17), 32'h100, 32'd0, 32'd0,
                   mk(4'd12, 32'h100, 32'h00012345, 5'd8, 1, 0, 0, 0)};
        vt[7]  = '{"beq_t",  enc_b(13'd16, 5'd2, 5'd1, 3'd0), 32'h40, 32'd9, 32'd9,
                   mk(4'd0, 32'h40, 32'd16, 5'd16, 0, 1, 0, 0)};
        vt[8]  = '{"beq_nt", enc_b(13'd16, 5'd2, 5'd1, 3'd0), 32'h40, 32'd9, 32'd8,
                   mk(4'd8, 32'h40, 32'd0, 5'd16, 0, 1, 0, 0)};
        vt[9]  = '{"add_x0", enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33), 32'h0, 32'd5, 32'd7,
                   mk(4'd0, 32'd5, 32'd7, 5'd0, 0, 0, 0, 0)};
        vt[10] = '{"jal",    enc_j(21'd8, 5'd1), 32'h200, 32'd0, 32'd0,
                   mk(4'd0, 32'h200, 32'd8, 5'd1, 1, 1, 32'h204, 0)};
        vt[11] = '{"lw",     enc_i(12'h004, 5'd1, 3'd2, 5'd9, 7'h03), 32'h0, 32'd3, 32'd0,
                   mk(4'd7, 32'd0, 32'd0, 5'd9, 0, 0, 0, 1)};
        vt[12] = '{"addi_n", enc_i(12'hFFF, 5'd1, 3'd0, 5'd10, 7'h13), 32'h0, 32'd10, 32'd0,
                   mk(4'd0, 32'd10, 32'hFFFFFFFF, 5'd10, 1, 0, 0, 0)};
        vt[13] = '{"slti",   enc_i(12'h003, 5'd1, 3'd2, 5'd11, 7'h13), 32'h0, 32'hFFFFFFFB, 32'd0,
                   mk(4'd6, 32'd0, 32'd0, 5'd11, 1, 0, 0, 0)};
        vt[14] = '{"jalr",   enc_i(12'hFFC, 5'd1, 3'd0, 5'd1, 7'h67), 32'h80, 32'h300, 32'd0,
                   mk(4'd0, 32'h300, 32'hFFFFFFFC, 5'd1, 1, 1, 32'h84, 0)};
        vt[15] = '{"bge_t",  enc_b(13'h1FF8, 5'd2, 5'd1, 3'd5), 32'h1000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                   mk(4'd0, 32'h1000, 32'hFFFFFFF8, 5'd25, 0, 1, 0, 0)};

        @(posedge clk);
        cycle("reset", 1'b1, 1'b0, 1'b1, add_i, 32'h0, 32'd5, 32'd7);
        check("reset_zero", '0);

        foreach (vt[i]) begin
            cycle("vec_rst", 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
            cycle(vt[i].name, 1'b1, 1'b0, 1'b0, vt[i].ins, vt[i].pc, vt[i].x1, vt[i].x2);
            check({vt[i].name, "_tbl"}, vt[i].e);
        end

        // Shadow: taken BEQ, four consumed instrs (one a JAL) with gaps, then live.
        cycle("sh_rst", 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        cycle("sh_beq", 1'b1, 1'b0, 1'b0, vt[7].ins, 32'h40, 32'd9, 32'd9);
        for (int k = 0; k < SHADOW; k++) begin
            cycle("sh_gap", 1'b0, 1'b0, 1'b0, add_i, 32'h44, 32'd5, 32'd7);
            check_bit("sh_gap_vld", vld, 1'b0);
            cycle("sh_sq", 1'b1, 1'b0, 1'b0, (k == 1) ? vt[10].ins : add_i, 32'h44, 32'd5, 32'd7);
            check_bit("sh_sq_vld", vld, 1'b0);
            check_bit("sh_sq_red", redirect, 1'b0);
        end
        cycle("sh_live", 1'b1, 1'b0, 1'b0, add_i, 32'h54, 32'd5, 32'd7);
        check("sh_live_tbl", vt[0].e);

        // Stall mid-squash freezes outputs and count; rst during stall clears.
        cycle("st_bne", 1'b1, 1'b0, 1'b0, enc_b(13'd16, 5'd2, 5'd1, 3'd1), 32'h40, 32'd1, 32'd1);
        check("st_bne_tbl", mk(4'd8, 32'h40, 32'd0, 5'd16, 0, 1, 0, 0));
        cycle("st_sq1", 1'b1, 1'b0, 1'b0, add_i, 32'h44, 32'd5, 32'd7);
        cycle("st_sq2", 1'b1, 1'b0, 1'b0, add_i, 32'h48, 32'd5, 32'd7);
        for (int k = 0; k < 3; k++) cycle("st_hold", 1'b1, 1'b1, 1'b0, add_i, 32'h4c, 32'd5, 32'd7);
        cycle("st_sq3", 1'b1, 1'b0, 1'b0, add_i, 32'h4c, 32'd5, 32'd7);
        cycle("st_sq4", 1'b1, 1'b0, 1'b0, add_i, 32'h50, 32'd5, 32'd7);
        check_bit("st_sq4_vld", vld, 1'b0);
        cycle("st_live", 1'b1, 1'b0, 1'b0, add_i, 32'h54, 32'd5, 32'd7);
        check("st_live_tbl", vt[0].e);
        cycle("rs_jal", 1'b1, 1'b0, 1'b0, vt[10].ins, 32'h200, 32'd0, 32'd0);
        cycle("rs_sq", 1'b1, 1'b0, 1'b0, add_i, 32'h204, 32'd5, 32'd7);
        cycle("rs_hold", 1'b1, 1'b1, 1'b0, add_i, 32'h208, 32'd5, 32'd7);
        cycle("rs_rst", 1'b1, 1'b1, 1'b1, add_i, 32'h208, 32'd5, 32'd7);
        check("rs_rst_zero", '0);
        cycle("rs_live", 1'b1, 1'b0, 1'b0, add_i, 32'h208, 32'd5, 32'd7);
        check("rs_live_tbl", vt[0].e);

        // Randomized traffic over the supported and unsupported opcode classes.
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h73, 7'h13};
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] x1, x2;
            int k;
            ri = $urandom;
            k = $urandom_range(0, 10);
            if (k < 10) ri[6:0] = opcs[k];
            if (k == 0) ri[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            if (k == 5 && $urandom_range(0, 3) != 0) ri[14:12] = 3'd0;
            x1 = $urandom;
            x2 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
            cycle("rand", ($urandom_range(0, 4) != 0), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 96) == 0), ri, $urandom, x1, x2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
